mem_access_arbiter: RTL

- Shares the single main-memory request port between the ICache miss path (read-only) and the DCache MSHRs (read and write).
- Allocates a read serial per outstanding read and a write serial per outstanding write, returning them in the ack.
- Recycles serials when the memory returns a read result or a write response.
- Sits between the caches and the AXI4 memory bridge; registered single-entry output stage.

---
 rtl/mem_access_arbiter_pkg.sv | 53 +++++
 rtl/mem_access_arbiter_free_list.sv | 76 +++++++
 rtl/mem_access_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared cache-system types: memory request/ack/result structs, serial widths
// and the arbiter's priority-pointer encoding.
package CacheSystemTypes;

    localparam int PHY_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MSHR_NUM       = 2;

    // One read serial per DCache MSHR plus one for the ICache miss path.
    localparam int MEM_ACCESS_SERIAL_NUM      = MSHR_NUM + 1;
    localparam int MEM_WRITE_SERIAL_NUM       = MSHR_NUM;
    localparam int MEM_ACCESS_SERIAL_BIT_SIZE = $clog2(MEM_ACCESS_SERIAL_NUM);
    localparam int MEM_WRITE_SERIAL_BIT_SIZE  = $clog2(MEM_WRITE_SERIAL_NUM);

    typedef logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] MemAccessSerial;
    typedef logic [MEM_WRITE_SERIAL_BIT_SIZE-1:0]  MemWriteSerial;

    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic [PHY_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] data;
    } MemAccessReq;

    typedef struct packed {
        logic           ack;
        MemAccessSerial serial;
        MemWriteSerial  wserial;
    } MemAccessReqAck;

    typedef struct packed {
        logic                      valid;
        MemAccessSerial            serial;
        logic [MEM_DATA_WIDTH-1:0] data;
    } MemAccessResult;

    typedef struct packed {
        logic          valid;
        MemWriteSerial serial;
    } MemAccessResponse;

    // Which requester wins the next contested grant.
    typedef enum logic {
        ARB_PRIO_DCACHE = 1'b0,
        ARB_PRIO_ICACHE = 1'b1
    } ArbPriority;

    // Index width for a pool of n entries; a single-entry pool still needs one bit.
    function automatic int SerialIndexWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_free_list.sv
// Serial free list: busy vector, lowest-free picker, one alloc and one free
// per cycle, plus a registered count of busy entries.
module mem_serial_free_list
    import CacheSystemTypes::*;
#(
    parameter int ENTRY_NUM = 2,
    parameter int IDX_WIDTH = SerialIndexWidth(ENTRY_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 allocEn_i,
    input  logic                 freeEn_i,
    input  logic [IDX_WIDTH-1:0] freeIdx_i,
    output logic [IDX_WIDTH-1:0] allocIdx_o,
    output logic                 empty_o,
    output logic [IDX_WIDTH:0]   busyCount_o
);

    logic [ENTRY_NUM-1:0] busy_q, busy_d;
    logic [IDX_WIDTH:0]   count_q, count_d;
    logic                 freeHit;

    // Lowest-index idle entry; looks only at registered state so a serial
    // freed this cycle cannot be handed out until the next one.
    always_comb begin
        allocIdx_o = '0;
        empty_o    = 1'b1;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                allocIdx_o = IDX_WIDTH'(i);
                empty_o    = 1'b0;
            end
        end
    end

    // Next busy vector: release a busy entry, claim the picked one, then count.
    always_comb begin
        busy_d  = busy_q;
        freeHit = 1'b0;
        count_d = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (freeEn_i && (freeIdx_i == IDX_WIDTH'(i)) && busy_q[i]) begin
                busy_d[i] = 1'b0;
                freeHit   = 1'b1;
            end
        end
        if (allocEn_i && !empty_o) begin
            busy_d[allocIdx_o] = 1'b1;
        end
        for (int i = 0; i < ENTRY_NUM; i++) begin
            count_d = count_d + {{IDX_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    // State register; reset drops every outstanding serial.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // A free aimed at an idle serial (e.g. a late return from before a reset) is dropped.
    always_ff @(posedge clk) begin
        if (!rst && freeEn_i) begin
            assert (freeHit)
            else $warning("free of idle serial %0d ignored", freeIdx_i);
        end
    end

    assign busyCount_o = count_q;

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the memory request port between the ICache miss path and the DCache
// MSHRs, hands out read/write serials and holds one registered request.
module mem_access_arbiter
    import CacheSystemTypes::*;
#(
    parameter int RD_SERIAL_NUM = MEM_ACCESS_SERIAL_NUM,
    parameter int WR_SERIAL_NUM = MEM_WRITE_SERIAL_NUM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              icReqValid,
    input  logic [PHY_ADDR_WIDTH-1:0]         icReqAddr,
    output logic                              icAck,
    output MemAccessSerial                    icSerial,
    input  MemAccessReq                       dcReq,
    output MemAccessReqAck                    dcAck,
    output MemAccessReq                       memReq,
    output MemAccessSerial                    memReqSerial,
    output MemWriteSerial                     memReqWSerial,
    input  logic                              memReqReady,
    input  MemAccessResult                    memResult,
    input  MemAccessResponse                  memResponse,
    output logic [MEM_ACCESS_SERIAL_BIT_SIZE:0] rdOutstanding
);

    MemAccessSerial                       rdAllocIdx;
    MemWriteSerial                        wrAllocIdx;
    logic                                 rdEmpty, wrEmpty;
    logic                                 rdAllocEn, wrAllocEn;
    logic [MEM_ACCESS_SERIAL_BIT_SIZE:0]  rdCount;
    logic [MEM_WRITE_SERIAL_BIT_SIZE:0]   wrCount;

    logic        slotOpen, icEligible, dcEligible, contested;
    logic        grantIc, grantDc;
    ArbPriority  prio_q, prio_d;
    MemAccessReq    memReq_q, memReq_d;
    MemAccessSerial memReqSerial_q, memReqSerial_d;
    MemWriteSerial  memReqWSerial_q, memReqWSerial_d;

    mem_serial_free_list #(
        .ENTRY_NUM (RD_SERIAL_NUM),
        .IDX_WIDTH (MEM_ACCESS_SERIAL_BIT_SIZE)
    ) rdFreeList (
        .clk         (clk),
        .rst         (rst),
        .allocEn_i   (rdAllocEn),
        .freeEn_i    (memResult.valid),
        .freeIdx_i   (memResult.serial),
        .allocIdx_o  (rdAllocIdx),
        .empty_o     (rdEmpty),
        .busyCount_o (rdCount)
    );

    mem_serial_free_list #(
        .ENTRY_NUM (WR_SERIAL_NUM),
        .IDX_WIDTH (MEM_WRITE_SERIAL_BIT_SIZE)
    ) wrFreeList (
        .clk         (clk),
        .rst         (rst),
        .allocEn_i   (wrAllocEn),
        .freeEn_i    (memResponse.valid),
        .freeIdx_i   (memResponse.serial),
        .allocIdx_o  (wrAllocIdx),
        .empty_o     (wrEmpty),
        .busyCount_o (wrCount)
    );

    // Grant selection: only when the output slot can take a request; the
    // pointer moves to the loser of a contested grant.
    always_comb begin
        slotOpen   = !memReq_q.valid || memReqReady;
        icEligible = icReqValid && !rdEmpty;
        dcEligible = dcReq.valid && (dcReq.we ? !wrEmpty : !rdEmpty);
        contested  = icEligible && dcEligible;
        grantIc    = 1'b0;
        grantDc    = 1'b0;
        prio_d     = prio_q;
        if (!rst && slotOpen) begin
            if (contested) begin
                if (prio_q == ARB_PRIO_DCACHE) begin
                    grantDc = 1'b1;
                    prio_d  = ARB_PRIO_ICACHE;
                end else begin
                    grantIc = 1'b1;
                    prio_d  = ARB_PRIO_DCACHE;
                end
            end else if (icEligible) begin
                grantIc = 1'b1;
            end else if (dcEligible) begin
                grantDc = 1'b1;
            end
        end
    end

    // Same-cycle acks; the serial field that does not apply stays zero.
    always_comb begin
        rdAllocEn = grantIc || (grantDc && !dcReq.we);
        wrAllocEn = grantDc && dcReq.we;
        icAck     = grantIc;
        icSerial  = grantIc ? rdAllocIdx : '0;
        dcAck     = '0;
        dcAck.ack = grantDc;
        if (grantDc) begin
            if (dcReq.we) begin
                dcAck.wserial = wrAllocIdx;
            end else begin
                dcAck.serial = rdAllocIdx;
            end
        end
    end

    // Output slot: load the granted request, drop it once consumed, else hold.
    always_comb begin
        memReq_d        = memReq_q;
        memReqSerial_d  = memReqSerial_q;
        memReqWSerial_d = memReqWSerial_q;
        if (grantIc) begin
            memReq_d.valid  = 1'b1;
            memReq_d.we     = 1'b0;
            memReq_d.addr   = icReqAddr;
            memReq_d.data   = '0;
            memReqSerial_d  = rdAllocIdx;
            memReqWSerial_d = '0;
        end else if (grantDc) begin
            memReq_d        = dcReq;
            memReq_d.valid  = 1'b1;
            memReqSerial_d  = dcReq.we ? '0 : rdAllocIdx;
            memReqWSerial_d = dcReq.we ? wrAllocIdx : '0;
        end else if (slotOpen) begin
            memReq_d.valid = 1'b0;
        end
    end

    // Output stage and priority pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            memReq_q        <= '0;
            memReqSerial_q  <= '0;
            memReqWSerial_q <= '0;
            prio_q          <= ARB_PRIO_DCACHE;
        end else begin
            memReq_q        <= memReq_d;
            memReqSerial_q  <= memReqSerial_d;
            memReqWSerial_q <= memReqWSerial_d;
            prio_q          <= prio_d;
        end
    end

    // Pool counters stay within their pool sizes and returned data is never X.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(rdCount) <= RD_SERIAL_NUM)
            else $error("read busy count %0d exceeds pool", rdCount);
            assert (int'(wrCount) <= WR_SERIAL_NUM)
            else $error("write busy count %0d exceeds pool", wrCount);
            if (memResult.valid) begin
                assert (!$isunknown(memResult.data))
                else $error("memResult data unknown");
            end
        end
    end

    assign memReq        = memReq_q;
    assign memReqSerial  = memReqSerial_q;
    assign memReqWSerial = memReqWSerial_q;
    assign rdOutstanding = rdCount;

endmodule
